rst_seq_ctrl: RTL

- Reset sequencer for the APB UART subsystem.
- Takes the board clock and power-on reset, plus soft-reset requests from the software reset bit and the watchdog.
- Drives ordered per-domain resets and clock enables, releasing them in order: APB fabric, then UART core, then the baud/IO domain.
- Acknowledges each requester when its reset sequence completes and keeps a sticky reset-cause register.

---
 rtl/rst_seq_pkg.sv | 27 ++
 rtl/rst_sync.sv | 25 ++
 rtl/rst_seq_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the APB UART reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_SYNC    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_ASSERT  = 3'd4
    } rst_seq_state_e;

    localparam int DEF_NUM_DOM     = 3;
    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DLY_W       = 8;
    localparam int DEF_HOLD_CYC    = 4;

    // Cause-register bit positions; requester i lives at CAUSE_REQ_BASE + i.
    localparam int CAUSE_POR      = 0;
    localparam int CAUSE_REQ_BASE = 1;

    // Width able to index/count 0..v-1, never narrower than one bit.
    function automatic int idx_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after SYNC_STAGES clock edges.
module rst_sync
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    output logic rst_n_sync_o
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift a constant one through the chain once reset_n is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_sync_o = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: ordered per-domain reset/clock-enable release after power-on and
// after soft-reset requests, with per-request acks and a sticky reset-cause register.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = DEF_NUM_DOM,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DLY_W       = DEF_DLY_W,
    parameter int HOLD_CYC    = DEF_HOLD_CYC
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       rst_req_i,
    output logic [NUM_REQ-1:0]       rst_ack_o,
    input  logic [NUM_DOM*DLY_W-1:0] dly_cfg_i,
    output logic [NUM_DOM-1:0]       dom_rst_n_o,
    output logic [NUM_DOM-1:0]       dom_clk_en_o,
    output logic                     busy_o,
    output logic [NUM_REQ:0]         rst_cause_o
);

    localparam int STEP_W  = idx_width(NUM_DOM);
    localparam int HOLD_W  = idx_width(HOLD_CYC);
    localparam int CAUSE_W = NUM_REQ + 1;
    localparam logic [CAUSE_W-1:0] POR_CAUSE = CAUSE_W'(1) << CAUSE_POR;

    rst_seq_state_e       state_r;
    logic [STEP_W-1:0]    step_r;
    logic [DLY_W-1:0]     cnt_r;
    logic [HOLD_W-1:0]    hold_r;
    logic [DLY_W-1:0]     dly_r [NUM_DOM];
    logic [NUM_REQ-1:0]   req_q_r;
    logic [NUM_REQ-1:0]   pending_r;
    logic [NUM_REQ-1:0]   in_service_r;
    logic [NUM_REQ-1:0]   ack_r;
    logic [CAUSE_W-1:0]   cause_r;
    logic [NUM_DOM-1:0]   dom_rst_n_r;
    logic [NUM_DOM-1:0]   dom_clk_en_r;
    logic                 busy_r;

    logic                 rst_n_sync_s;
    logic [NUM_REQ-1:0]   rise_s;
    logic [STEP_W-1:0]    nxt_step_s;
    logic [DLY_W-1:0]     nxt_dly_s;
    logic                 last_step_s;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .rst_n_sync_o (rst_n_sync_s)
    );

    // Request rising edges and the release delay of the step after the current one.
    always_comb begin
        rise_s      = rst_req_i & ~req_q_r;
        nxt_step_s  = step_r + STEP_W'(1);
        nxt_dly_s   = '0;
        for (int d = 0; d < NUM_DOM; d++) begin
            nxt_dly_s = (STEP_W'(d) == nxt_step_s) ? dly_r[d] : nxt_dly_s;
        end
        last_step_s = (step_r == STEP_W'(NUM_DOM - 1));
    end

    // Registered copy of the requests; frozen low in RESET so a level held through
    // power-on is seen as one fresh edge once the sequencer leaves RESET.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q_r <= '0;
        end else if (state_r != ST_RESET) begin
            req_q_r <= rst_req_i;
        end else begin
            req_q_r <= '0;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_RESET;
            step_r       <= '0;
            cnt_r        <= '0;
            hold_r       <= '0;
            for (int d = 0; d < NUM_DOM; d++) begin
                dly_r[d] <= '0;
            end
            pending_r    <= '0;
            in_service_r <= '0;
            ack_r        <= '0;
            cause_r      <= POR_CAUSE;
            dom_rst_n_r  <= '0;
            dom_clk_en_r <= '0;
            busy_r       <= 1'b1;
        end else begin
            ack_r <= '0;
            if (state_r != ST_RESET) begin
                pending_r <= pending_r | rise_s;
            end

            case (state_r)
                ST_RESET: begin
                    if (rst_n_sync_s) begin
                        state_r <= ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    for (int d = 0; d < NUM_DOM; d++) begin
                        dly_r[d] <= dly_cfg_i[d*DLY_W +: DLY_W];
                    end
                    step_r  <= '0;
                    cnt_r   <= dly_cfg_i[DLY_W-1:0];
                    if (dly_cfg_i[DLY_W-1:0] == '0) begin
                        dom_clk_en_r[0] <= 1'b1;
                    end
                    state_r <= ST_RELEASE;
                end

                // Clock enable goes up when the count reaches zero, reset one cycle later.
                ST_RELEASE: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - DLY_W'(1);
                        if (cnt_r == DLY_W'(1)) begin
                            dom_clk_en_r[step_r] <= 1'b1;
                        end
                    end else begin
                        dom_rst_n_r[step_r] <= 1'b1;
                        if (last_step_s) begin
                            state_r      <= ST_RUN;
                            busy_r       <= 1'b0;
                            ack_r        <= in_service_r;
                            in_service_r <= '0;
                        end else begin
                            step_r <= nxt_step_s;
                            cnt_r  <= nxt_dly_s;
                            if (nxt_dly_s == '0) begin
                                dom_clk_en_r[nxt_step_s] <= 1'b1;
                            end
                        end
                    end
                end

                ST_RUN: begin
                    if (pending_r != '0) begin
                        state_r      <= ST_ASSERT;
                        busy_r       <= 1'b1;
                        in_service_r <= pending_r;
                        pending_r    <= rise_s;
                        cause_r      <= {pending_r, 1'b0};
                        dom_rst_n_r  <= '0;
                        hold_r       <= HOLD_W'(HOLD_CYC - 1);
                    end
                end

                ST_ASSERT: begin
                    dom_clk_en_r <= '0;
                    if (hold_r == '0) begin
                        state_r <= ST_SYNC;
                    end else begin
                        hold_r <= hold_r - HOLD_W'(1);
                    end
                end

                default: begin
                    state_r <= ST_RESET;
                end
            endcase
        end
    end

    assign rst_ack_o    = ack_r;
    assign dom_rst_n_o  = dom_rst_n_r;
    assign dom_clk_en_o = dom_clk_en_r;
    assign busy_o       = busy_r;
    assign rst_cause_o  = cause_r;

endmodule
